instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 2, output-buffer entries; power of two, minimum 2.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request carries a field set to encode.
REQ-006 in_ready  out  1  block can accept a request this cycle.
REQ-007 fmt  in  1  0 = R-type, 1 = I-type.
REQ-008 opcode  in  4  instruction opcode.
REQ-009 m  in  1  I-type mode bit; ignored for R-type.
REQ-010 rd, rs1, rs2  in  3 each  register fields; rs2 ignored for I-type.
REQ-011 imm  in  5  I-type immediate; ignored for R-type.
REQ-012 out_valid  out  1  instr holds an encoded word.
REQ-013 out_ready  in  1  consumer takes instr this cycle.
REQ-014 instr  out  16  encoded instruction word.
REQ-015 enc_count  out  8  count of words delivered.

Function
REQ-016 Encoding SHALL be R-type: opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3], 3'b000 at [2:0].
REQ-017 Encoding SHALL be I-type: opcode[15:12], m[11], rd[10:8], rs1[7:5], imm[4:0].
REQ-018 Encoding SHALL occur at acceptance (in_valid && in_ready); the packed word is stored, and later input changes SHALL NOT affect it.
REQ-019 Buffer SHALL be a FIFO of DEPTH entries with write/read pointers wrapping modulo DEPTH and an occupancy counter of 0..DEPTH.
REQ-020 Occupancy state SHALL be EMPTY (0), PARTIAL (1..DEPTH-1) or FULL (DEPTH); the state follows the counter after each edge.
REQ-021 in_ready SHALL be 1 iff not FULL; it is combinational from state only, with no dependency on out_ready.
REQ-022 out_valid SHALL be 1 iff not EMPTY; instr SHALL equal the head entry while out_valid=1 and 16'h0000 while EMPTY.
REQ-023 Latency SHALL be one cycle: a word accepted at edge N is presented with out_valid=1 after edge N when the FIFO was empty.
REQ-024 There SHALL be no combinational bypass from input to output.
REQ-025 Pop SHALL occur when out_valid && out_ready; instr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 On a simultaneous push and pop in PARTIAL, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-027 When FULL, push SHALL be blocked (in_ready=0) even if a pop occurs in the same cycle.
REQ-028 When EMPTY, a pop SHALL be impossible (out_valid=0); a push moves the state to PARTIAL, or to FULL when DEPTH=1 is excluded.
REQ-029 enc_count SHALL increment by 1 on each pop and wrap 8'hFF -> 8'h00.
REQ-030 Words SHALL leave in acceptance order, with no loss or duplication.

Reset
REQ-031 On reset assertion, asynchronously: pointers=0, occupancy=0 (EMPTY), out_valid=0, instr=16'h0000, enc_count=0, in_ready=1.
REQ-032 Reset mid-operation SHALL discard all buffered words; no pop is counted for them.
REQ-033 The first acceptance SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-034 R-type, opcode=4'h1, rd=101, rs1=011, rs2=110, out_ready=1 -> next cycle out_valid=1, instr=16'h1AF0; enc_count=1 after the pop edge.
REQ-035 I-type, opcode=4'h5, m=1, rd=010, rs1=111, imm=10011 -> instr=16'h5AF3.
REQ-036 out_ready=0, push 3 words (DEPTH=2) -> in_ready=0 after 2 accepts; third held; out_ready=1 -> words pop in order and the third is accepted the cycle after FULL clears.
REQ-037 PARTIAL with in_valid=1 and out_ready=1 for 10 cycles -> occupancy stays 1, pointers wrap, 10 words out in order.
REQ-038 256 pops -> enc_count wraps to 8'h00.
REQ-039 Reset asserted mid-cycle with 2 words buffered -> out_valid=0, instr=16'h0000, enc_count=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs R/I-type field sets into 16-bit words
// and buffers them in a small FIFO towards a valid/ready consumer.
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        fmt,
    input  logic [3:0]  opcode,
    input  logic        m,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    input  logic [4:0]  imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] instr,
    output logic [7:0]  enc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      enc_count_q, enc_count_d;
    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     word;
    logic            push;
    logic            pop;

    // Handshake status comes only from the registered occupancy state.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign instr     = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign enc_count = enc_count_q;

    // Pack the presented field set into the selected instruction format.
    always_comb begin
        word = 16'h0000;
        if (fmt) begin
            word = {opcode, m, rd, rs1, imm};
        end else begin
            word = {opcode, rd, rs1, rs2, 3'b000};
        end
    end

    // Next pointers, occupancy, delivered-word count and occupancy state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        enc_count_d = enc_count_q;
        state_d     = state_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            enc_count_d = enc_count_q + 8'd1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == FULL_CNT) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    // Control state register; reset empties the buffer at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            enc_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            enc_count_q <= enc_count_d;
        end
    end

    // Storage captures the packed word at acceptance; contents are
    // masked by out_valid so they need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder (DEPTH=2) with
// hand-computed encoded words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        fmt;
    logic [3:0]  opcode;
    logic        m;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [4:0]  imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr;
    logic [7:0]  enc_count;

    int nvec = 0;
    int nmis = 0;
    logic [7:0]  exp_cnt;
    logic [15:0] exp_w;
    logic [2:0]  k3;
    logic [3:0]  k4;

    instr_encoder #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .m         (m),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_r(input logic [3:0] op, input logic [2:0] d,
                           input logic [2:0] s1, input logic [2:0] s2,
                           input logic mm, input logic [4:0] im);
        in_valid = 1'b1;
        fmt      = 1'b0;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        m        = mm;
        imm      = im;
    endtask

    task automatic drive_i(input logic [3:0] op, input logic mm,
                           input logic [2:0] d, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [4:0] im);
        in_valid = 1'b1;
        fmt      = 1'b1;
        opcode   = op;
        m        = mm;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        fmt       = 1'b0;
        opcode    = 4'h0;
        m         = 1'b0;
        rd        = 3'd0;
        rs1       = 3'd0;
        rs2       = 3'd0;
        imm       = 5'd0;
        out_ready = 1'b0;
        exp_cnt   = 8'h00;

        #2;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_enc_count", 16'(enc_count), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);

        // R-type, consumer ready: one-cycle latency, then pop
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        drive_r(4'h1, 3'b101, 3'b011, 3'b110, 1'b1, 5'h1F);
        @(negedge clk);
        in_valid = 1'b0;
        chk("r_valid", 16'(out_valid), 16'd1);
        chk("r_instr", instr, 16'h1AF0);
        chk("r_cnt_pre", 16'(enc_count), 16'd0);
        @(negedge clk);
        exp_cnt = 8'd1;
        chk("r_cnt_post", 16'(enc_count), 16'(exp_cnt));
        chk("r_empty", 16'(out_valid), 16'd0);
        chk("r_instr_empty", instr, 16'h0000);

        // I-type, consumer stalled: word must be held and isolated
        out_ready = 1'b0;
        drive_i(4'h5, 1'b1, 3'b010, 3'b111, 3'b101, 5'b10011);
        @(negedge clk);
        in_valid = 1'b0;
        chk("i_instr", instr, 16'h5AF3);
        drive_i(4'h9, 1'b0, 3'b001, 3'b000, 3'b000, 5'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("i_hold", instr, 16'h5AF3);
        chk("i_hold_cnt", 16'(enc_count), 16'(exp_cnt));
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("i_cnt", 16'(enc_count), 16'(exp_cnt));
        chk("i_empty", 16'(out_valid), 16'd0);

        // Fill to FULL with the consumer stalled, third word held
        out_ready = 1'b0;
        drive_r(4'h2, 3'd1, 3'd2, 3'd3, 1'b1, 5'h15);
        @(negedge clk);
        chk("f_rdy1", 16'(in_ready), 16'd1);
        drive_i(4'h3, 1'b0, 3'd4, 3'd5, 3'd7, 5'h1F);
        @(negedge clk);
        chk("f_full_rdy", 16'(in_ready), 16'd0);
        chk("f_head_a", instr, 16'h2298);
        drive_r(4'hF, 3'd7, 3'd7, 3'd7, 1'b1, 5'h1F);
        @(negedge clk);
        chk("f_block_rdy", 16'(in_ready), 16'd0);
        chk("f_hold_a", instr, 16'h2298);
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("f_pop_a_no_push", 16'(in_ready), 16'd1);
        chk("f_head_b", instr, 16'h34BF);
        @(negedge clk);
        exp_cnt++;
        in_valid = 1'b0;
        chk("f_head_c", instr, 16'hFFF8);
        chk("f_c_valid", 16'(out_valid), 16'd1);
        @(negedge clk);
        exp_cnt++;
        chk("f_drained", 16'(out_valid), 16'd0);
        chk("f_cnt", 16'(enc_count), 16'(exp_cnt));

        // Steady push+pop at occupancy 1, pointers wrap repeatedly
        out_ready = 1'b0;
        drive_r(4'h0, 3'd0, 3'd7, 3'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("s_w0", instr, 16'h01C0);
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            k3 = 3'(k);
            k4 = 4'(k);
            drive_r(k4, k3, ~k3, k3, 1'b0, 5'd0);
            @(negedge clk);
            exp_cnt++;
            exp_w = {k4, k3, ~k3, k3, 3'b000};
            chk($sformatf("s_w%0d", k), instr, exp_w);
            chk($sformatf("s_occ%0d", k),
                16'({in_ready, out_valid}), 16'b11);
        end
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt++;
        chk("s_drained", 16'(out_valid), 16'd0);
        chk("s_cnt", 16'(enc_count), 16'(exp_cnt));

        // Stream until enc_count wraps through 8'hFF to 8'h00
        drive_r(4'h7, 3'd3, 3'd3, 3'd3, 1'b0, 5'd0);
        @(negedge clk);
        while (exp_cnt != 8'hFF) begin
            @(negedge clk);
            exp_cnt++;
        end
        chk("wrap_ff", 16'(enc_count), 16'h00FF);
        @(negedge clk);
        exp_cnt++;
        chk("wrap_00", 16'(enc_count), 16'h0000);
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt++;
        chk("wrap_01", 16'(enc_count), 16'h0001);

        // Reset mid-cycle with two words buffered
        out_ready = 1'b0;
        drive_r(4'hA, 3'd1, 3'd1, 3'd1, 1'b0, 5'd0);
        @(negedge clk);
        drive_r(4'hB, 3'd2, 3'd2, 3'd2, 1'b0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_full", 16'(in_ready), 16'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mr_valid", 16'(out_valid), 16'd0);
        chk("mr_instr", instr, 16'h0000);
        chk("mr_cnt", 16'(enc_count), 16'd0);
        chk("mr_rdy", 16'(in_ready), 16'd1);

        // First edge after release accepts; old words stay gone
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        drive_i(4'hC, 1'b0, 3'd6, 3'd1, 3'd0, 5'h0A);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pr_instr", instr, 16'hC62A);
        @(negedge clk);
        chk("pr_empty", 16'(out_valid), 16'd0);
        chk("pr_cnt", 16'(enc_count), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
